// File: rtl/alu_seq_unit.sv
// Registered 8-op ALU; MOD is a WIDTH-iteration restoring remainder, all other ops take one cycle.
// Optional zero/overflow flag outputs are enabled by defining ALU_FLAGS_EN.
module alu_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic {IDLE, MOD_RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_iter;
  logic             accept_single;

  assign add_res = a + b;
  assign sub_res = a - b;

  always_comb begin
    op_res = '0;
    case (alu_op)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_XOR:  op_res = a ^ b;
      OP_NOR:  op_res = ~(a | b);
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_ADD:  op_res = add_res;
      OP_SUB:  op_res = sub_res;
      default: op_res = a;  // remainder by a zero divisor returns the dividend
    endcase
  end

  // One restoring step; the extra top bit keeps the compare exact when rem's MSB shifts out.
  assign rem_shift = {rem_reg, dividend_reg[WIDTH-1]};
  assign rem_iter  = (rem_shift >= {1'b0, divisor_reg}) ? (rem_shift[WIDTH-1:0] - divisor_reg)
                                                       : rem_shift[WIDTH-1:0];

  assign accept_single = start && ((alu_op != OP_MOD) || (b == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && (alu_op == OP_MOD) && (b != '0)) state_next = MOD_RUN;
      MOD_RUN: if (cnt_reg == CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    result_next   = result_reg;
    done_next     = 1'b0;
    rem_next      = rem_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept_single) begin
          result_next = op_res;
          done_next   = 1'b1;
        end else if (start) begin
          dividend_next = a;
          divisor_next  = b;
          rem_next      = '0;
          cnt_next      = CNT_W'(WIDTH);
        end
      end
      MOD_RUN: begin
        rem_next      = rem_iter;
        dividend_next = dividend_reg << 1;
        cnt_next      = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          result_next = rem_iter;
          done_next   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      done_reg     <= 1'b0;
      rem_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      cnt_reg      <= '0;
    end else begin
      result_reg   <= result_next;
      done_reg     <= done_next;
      rem_reg      <= rem_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign result = result_reg;
  assign done   = done_reg;
  assign busy   = (state_reg == MOD_RUN);

`ifdef ALU_FLAGS_EN
  logic zero_reg, overflow_reg;
  logic ovf_op;

  // Flags follow the op that is completing; a finishing MOD never overflows.
  always_comb begin
    ovf_op = 1'b0;
    if (state_reg == IDLE) begin
      if (alu_op == OP_ADD)
        ovf_op = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      else if (alu_op == OP_SUB)
        ovf_op = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (done_next) begin
      zero_reg     <= (result_next == '0);
      overflow_reg <= ovf_op;
    end
  end

  assign zero     = zero_reg;
  assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed-vector bench for alu_seq_unit at WIDTH=8; flag checks compile in with ALU_FLAGS_EN.
module tb_alu_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] alu_op;
  logic [7:0] a, b;
  logic [7:0] result;
  logic       done, busy;
`ifdef ALU_FLAGS_EN
  logic       zero, overflow;
`endif

  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .result(result), .done(done), .busy(busy)
`ifdef ALU_FLAGS_EN
    , .zero(zero), .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request before the edge, return 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    start = 1'b1; alu_op = op; a = av; b = bv;
    $display("issue op=%0d a=%02h b=%02h", op, av, bv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int edges, busy_cnt, late_done;
    rst_n = 1'b0; start = 1'b0; alu_op = 3'd0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    issue(3'b101, 8'h7F, 8'h01);
    check("add_result", 32'(result), 32'h80);
    check("add_done", 32'(done), 32'h1);
    check("add_busy", 32'(busy), 32'h0);
`ifdef ALU_FLAGS_EN
    check("add_ovf", 32'(overflow), 32'h1);
    check("add_zero", 32'(zero), 32'h0);
`endif
    @(posedge clk); #1;
    check("done_pulse_len", 32'(done), 32'h0);
    check("result_hold", 32'(result), 32'h80);

    issue(3'b100, 8'hFE, 8'h03);
    check("slt_neg_lt", 32'(result), 32'h01);
    issue(3'b100, 8'h03, 8'hFE);
    check("slt_pos_ge", 32'(result), 32'h00);
    issue(3'b110, 8'h05, 8'h05);
    check("sub_zero", 32'(result), 32'h00);
`ifdef ALU_FLAGS_EN
    check("sub_zero_flag", 32'(zero), 32'h1);
`endif
    issue(3'b110, 8'h03, 8'h05);
    check("sub_wrap", 32'(result), 32'hFE);
`ifdef ALU_FLAGS_EN
    check("sub_wrap_ovf", 32'(overflow), 32'h0);
`endif

    // 200 mod 7 with an ignored AND request injected mid-run
    issue(3'b111, 8'd200, 8'd7);
    check("mod_busy_rise", 32'(busy), 32'h1);
    edges = 0; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      if (busy) busy_cnt++;
      if (k == 3) begin start = 1'b1; alu_op = 3'b000; a = 8'hFF; b = 8'hFF; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (done && busy) check("done_with_busy", 32'(busy), 32'h0);
    end
    start = 1'b0;
    check("mod_edges", 32'(edges), 32'd8);
    check("mod_busy_cycles", 32'(busy_cnt), 32'd8);
    check("mod_done", 32'(done), 32'h1);
    check("mod_result", 32'(result), 32'd4);
    check("mod_busy_fall", 32'(busy), 32'h0);
`ifdef ALU_FLAGS_EN
    check("mod_ovf", 32'(overflow), 32'h0);
`endif
    repeat (2) @(posedge clk); #1;
    check("mod_result_hold", 32'(result), 32'd4);
    check("mod_no_extra_done", 32'(done), 32'h0);

    issue(3'b111, 8'd13, 8'd0);
    check("mod0_result", 32'(result), 32'd13);
    check("mod0_done", 32'(done), 32'h1);
    check("mod0_busy", 32'(busy), 32'h0);

    // Reset partway through a MOD aborts it
    issue(3'b111, 8'hFF, 8'h10);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) late_done++;
    end
    check("abort_no_late_done", 32'(late_done), 32'd0);

    issue(3'b011, 8'h0F, 8'hF0);
    check("nor_result", 32'(result), 32'h00);
    check("nor_done", 32'(done), 32'h1);

    // Back-to-back single-cycle ops
    @(negedge clk);
    start = 1'b1; alu_op = 3'b000; a = 8'hCC; b = 8'hAA;
    $display("issue back-to-back AND/OR/XOR a=CC b=AA");
    @(posedge clk); #1;
    check("b2b_and", 32'(result), 32'h88);
    check("b2b_and_done", 32'(done), 32'h1);
    alu_op = 3'b001;
    @(posedge clk); #1;
    check("b2b_or", 32'(result), 32'hEE);
    check("b2b_or_done", 32'(done), 32'h1);
    alu_op = 3'b010;
    @(posedge clk); #1;
    check("b2b_xor", 32'(result), 32'h66);
    check("b2b_xor_done", 32'(done), 32'h1);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b_done_end", 32'(done), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
